tc_sram_hs: RTL and testbench

// Multi-port generic SRAM with per-port valid/ready request and response handshakes.

---
 rtl/tc_sram_hs_pkg.sv | 32 +++
 rtl/tc_sram_hs_if.sv | 32 +++
 rtl/tc_sram_hs_rsp_fifo.sv | 66 ++++++
 rtl/tc_sram_hs.sv | 183 ++++++++++++++++++
 tb/tb_tc_sram_hs.sv | 285 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/tc_sram_hs_pkg.sv
// rtl/tc_sram_hs_pkg.sv - shared constants, types and init helper for tc_sram_hs
package tc_sram_hs_pkg;

    localparam string SIM_INIT_ZEROS  = "zeros";
    localparam string SIM_INIT_ONES   = "ones";
    localparam string SIM_INIT_RANDOM = "random";
    localparam string SIM_INIT_NONE   = "none";

    localparam int unsigned DEF_NUM_WORDS  = 1024;
    localparam int unsigned DEF_DATA_WIDTH = 64;
    localparam int unsigned DEF_BYTE_WIDTH = 8;
    localparam int unsigned DEF_NUM_PORTS  = 2;
    localparam int unsigned DEF_ADDR_WIDTH = (DEF_NUM_WORDS > 1) ? $clog2(DEF_NUM_WORDS) : 1;
    localparam int unsigned DEF_BE_WIDTH   = (DEF_DATA_WIDTH + DEF_BYTE_WIDTH - 1) / DEF_BYTE_WIDTH;

    typedef logic [DEF_ADDR_WIDTH-1:0] addr_t;
    typedef logic [DEF_DATA_WIDTH-1:0] data_t;
    typedef logic [DEF_BE_WIDTH-1:0]   be_t;

    typedef struct packed {
        data_t data;
        logic  err;
    } rsp_t;

    // Deterministic per-word scramble used for the "random" initial image.
    function automatic logic [63:0] init_pattern(input int unsigned idx);
        logic [31:0] h;
        h = (idx * 32'h9E37_79B1) ^ 32'h5BD1_E995;
        return {h ^ 32'hA5A5_5A5A, ~h};
    endfunction

endpackage

// File: rtl/tc_sram_hs_if.sv
// rtl/tc_sram_hs_if.sv - per-port request/response handshake bundle for tc_sram_hs
interface tc_sram_hs_if
    import tc_sram_hs_pkg::*;
#(
    parameter int unsigned NumPorts  = DEF_NUM_PORTS,
    parameter int unsigned AddrWidth = DEF_ADDR_WIDTH,
    parameter int unsigned DataWidth = DEF_DATA_WIDTH,
    parameter int unsigned BeWidth   = DEF_BE_WIDTH
);

    logic [NumPorts-1:0]           req_valid_i;
    logic [NumPorts-1:0]           req_ready_o;
    logic [NumPorts-1:0]           req_we_i;
    logic [NumPorts*AddrWidth-1:0] req_addr_i;
    logic [NumPorts*DataWidth-1:0] req_wdata_i;
    logic [NumPorts*BeWidth-1:0]   req_be_i;
    logic [NumPorts-1:0]           rsp_valid_o;
    logic [NumPorts-1:0]           rsp_ready_i;
    logic [NumPorts*DataWidth-1:0] rsp_rdata_o;
    logic [NumPorts-1:0]           rsp_err_o;

    modport master (
        output req_valid_i, req_we_i, req_addr_i, req_wdata_i, req_be_i, rsp_ready_i,
        input  req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o
    );

    modport slave (
        input  req_valid_i, req_we_i, req_addr_i, req_wdata_i, req_be_i, rsp_ready_i,
        output req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o
    );

endinterface

// File: rtl/tc_sram_hs_rsp_fifo.sv
// rtl/tc_sram_hs_rsp_fifo.sv - fall-through response FIFO, one per port
module tc_sram_hs_rsp_fifo
    import tc_sram_hs_pkg::*;
#(
    parameter int unsigned Depth = 2,
    parameter int unsigned Width = DEF_DATA_WIDTH + 1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             s_tvalid,
    input  logic [Width-1:0] s_tdata,
    output logic             m_tvalid,
    input  logic             m_tready,
    output logic [Width-1:0] m_tdata
);

    localparam int unsigned PtrWidth = (Depth > 1) ? $clog2(Depth) : 1;
    localparam int unsigned CntWidth = $clog2(Depth + 1);
    localparam logic [PtrWidth-1:0] LastPtr = PtrWidth'(Depth - 1);

    logic [Width-1:0]    buf_q [Depth];
    logic [PtrWidth-1:0] rd_ptr_q;
    logic [PtrWidth-1:0] wr_ptr_q;
    logic [CntWidth-1:0] count_q;
    logic                empty;
    logic                push;
    logic                pop;

    // Empty FIFO passes the input straight through; only unconsumed entries are stored.
    always_comb begin
        empty    = (count_q == '0);
        m_tvalid = ~empty | s_tvalid;
        m_tdata  = empty ? s_tdata : buf_q[rd_ptr_q];
        push     = s_tvalid & ~(empty & m_tready);
        pop      = ~empty & m_tready;
    end

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= (wr_ptr_q == LastPtr) ? '0 : wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= (rd_ptr_q == LastPtr) ? '0 : rd_ptr_q + 1'b1;
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // Entry storage; contents are only meaningful while counted.
    always_ff @(posedge clk_i) begin
        if (push) begin
            buf_q[wr_ptr_q] <= s_tdata;
        end
    end

endmodule

// File: rtl/tc_sram_hs.sv
// rtl/tc_sram_hs.sv - multi-port handshaked SRAM; TC_SRAM_HS_PARITY_EN adds per-byte even parity
module tc_sram_hs
    import tc_sram_hs_pkg::*;
#(
    parameter int unsigned NumWords  = DEF_NUM_WORDS,
    parameter int unsigned DataWidth = DEF_DATA_WIDTH,
    parameter int unsigned ByteWidth = DEF_BYTE_WIDTH,
    parameter int unsigned NumPorts  = DEF_NUM_PORTS,
    parameter int unsigned Latency   = 1,
    parameter int unsigned RspDepth  = 2,
    parameter string       SimInit   = SIM_INIT_NONE
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    tc_sram_hs_if.slave bus
);

    localparam int unsigned AddrWidth = (NumWords > 1) ? $clog2(NumWords) : 1;
    localparam int unsigned BeWidth   = (DataWidth + ByteWidth - 1) / ByteWidth;
    localparam int unsigned CntWidth  = $clog2(RspDepth + 1);
    localparam int unsigned RspWidth  = DataWidth + 1;
    localparam logic [AddrWidth:0]  NumWordsW = (AddrWidth + 1)'(NumWords);
    localparam logic [CntWidth-1:0] DepthW    = CntWidth'(RspDepth);

    logic [DataWidth-1:0] mem_q [NumWords];
`ifdef TC_SRAM_HS_PARITY_EN
    logic [BeWidth-1:0]   par_q [NumWords];
`endif

    logic [NumPorts-1:0][AddrWidth-1:0] addr;
    logic [NumPorts-1:0][DataWidth-1:0] wdata;
    logic [NumPorts-1:0][BeWidth-1:0]   be;
    logic [NumPorts-1:0]                in_range;
    logic [NumPorts-1:0]                ready;
    logic [NumPorts-1:0]                rd_acc;
    logic [NumPorts-1:0]                wr_acc;
    logic [NumPorts-1:0][DataWidth-1:0] rd_data;
    logic [NumPorts-1:0]                rd_err;
    logic [NumPorts-1:0]                rsp_valid;
    logic [NumPorts-1:0]                rsp_hs;
    logic [NumPorts-1:0][RspWidth-1:0]  fifo_out;
    logic [NumPorts-1:0][CntWidth-1:0]  credit_q;

    logic [NumPorts-1:0][Latency-1:0]                pipe_valid_q;
    logic [NumPorts-1:0][Latency-1:0]                pipe_err_q;
    logic [NumPorts-1:0][Latency-1:0][DataWidth-1:0] pipe_data_q;

    function automatic logic [DataWidth-1:0] init_word(input int unsigned idx);
        if (SimInit == SIM_INIT_ZEROS) return '0;
        if (SimInit == SIM_INIT_ONES)  return '1;
        return DataWidth'(init_pattern(idx));
    endfunction

`ifdef TC_SRAM_HS_PARITY_EN
    function automatic logic [BeWidth-1:0] byte_parity(input logic [DataWidth-1:0] d);
        logic [BeWidth-1:0] p;
        p = '0;
        for (int i = 0; i < DataWidth; i++) begin
            p[i / ByteWidth] = p[i / ByteWidth] ^ d[i];
        end
        return p;
    endfunction
`endif

    // Unpack the flat port buses, decide acceptance and sample the array for reads.
    always_comb begin
        for (int p = 0; p < NumPorts; p++) begin
            addr[p]     = bus.req_addr_i[p*AddrWidth +: AddrWidth];
            wdata[p]    = bus.req_wdata_i[p*DataWidth +: DataWidth];
            be[p]       = bus.req_be_i[p*BeWidth +: BeWidth];
            in_range[p] = ({1'b0, addr[p]} < NumWordsW);
            ready[p]    = (credit_q[p] < DepthW);
            rd_acc[p]   = bus.req_valid_i[p] & ready[p] & ~bus.req_we_i[p];
            wr_acc[p]   = bus.req_valid_i[p] & ready[p] & bus.req_we_i[p];
            rd_data[p]  = '0;
            rd_err[p]   = 1'b1;
            if (in_range[p]) begin
                rd_data[p] = mem_q[addr[p]];
`ifdef TC_SRAM_HS_PARITY_EN
                rd_err[p]  = (byte_parity(mem_q[addr[p]]) != par_q[addr[p]]);
`else
                rd_err[p]  = 1'b0;
`endif
            end
        end
    end

    // Array update: ports applied in ascending order so the highest index wins per byte.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            if (SimInit != SIM_INIT_NONE) begin
                for (int w = 0; w < NumWords; w++) begin
                    mem_q[w] <= init_word(w);
`ifdef TC_SRAM_HS_PARITY_EN
                    par_q[w] <= byte_parity(init_word(w));
`endif
                end
            end
        end else begin
            for (int p = 0; p < NumPorts; p++) begin
                if (wr_acc[p] && in_range[p]) begin
                    for (int i = 0; i < DataWidth; i++) begin
                        if (be[p][i / ByteWidth]) begin
                            mem_q[addr[p]][i] <= wdata[p][i];
                        end
                    end
`ifdef TC_SRAM_HS_PARITY_EN
                    for (int b = 0; b < BeWidth; b++) begin
                        if (be[p][b]) begin
                            par_q[addr[p]][b] <= byte_parity(wdata[p])[b];
                        end
                    end
`endif
                end
            end
        end
    end

    // Read latency shift register; stage 0 captures the array at the accept edge.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pipe_valid_q <= '0;
            pipe_err_q   <= '0;
            pipe_data_q  <= '0;
        end else begin
            for (int p = 0; p < NumPorts; p++) begin
                for (int s = int'(Latency) - 1; s > 0; s--) begin
                    pipe_valid_q[p][s] <= pipe_valid_q[p][s-1];
                    pipe_err_q[p][s]   <= pipe_err_q[p][s-1];
                    pipe_data_q[p][s]  <= pipe_data_q[p][s-1];
                end
                pipe_valid_q[p][0] <= rd_acc[p];
                pipe_err_q[p][0]   <= rd_err[p];
                pipe_data_q[p][0]  <= rd_data[p];
            end
        end
    end

    // Credits count reads in the pipeline plus the FIFO, so the FIFO never overflows.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            credit_q <= '0;
        end else begin
            for (int p = 0; p < NumPorts; p++) begin
                case ({rd_acc[p], rsp_hs[p]})
                    2'b10:   credit_q[p] <= credit_q[p] + 1'b1;
                    2'b01:   credit_q[p] <= credit_q[p] - 1'b1;
                    default: credit_q[p] <= credit_q[p];
                endcase
            end
        end
    end

    for (genvar p = 0; p < NumPorts; p++) begin : g_port
        tc_sram_hs_rsp_fifo #(
            .Depth (RspDepth),
            .Width (RspWidth)
        ) u_rsp_fifo (
            .clk_i    (clk_i),
            .rst_ni   (rst_ni),
            .s_tvalid (pipe_valid_q[p][Latency-1]),
            .s_tdata  ({pipe_err_q[p][Latency-1], pipe_data_q[p][Latency-1]}),
            .m_tvalid (rsp_valid[p]),
            .m_tready (bus.rsp_ready_i[p]),
            .m_tdata  (fifo_out[p])
        );
    end

    assign rsp_hs          = rsp_valid & bus.rsp_ready_i;
    assign bus.req_ready_o = ready;

    // Drive responses; data and error read as zero whenever no response is offered.
    always_comb begin
        bus.rsp_valid_o = rsp_valid;
        bus.rsp_rdata_o = '0;
        bus.rsp_err_o   = '0;
        for (int p = 0; p < NumPorts; p++) begin
            bus.rsp_rdata_o[p*DataWidth +: DataWidth] = rsp_valid[p] ? fifo_out[p][DataWidth-1:0] : '0;
            bus.rsp_err_o[p] = rsp_valid[p] & fifo_out[p][DataWidth];
        end
    end

endmodule

// File: tb/tb_tc_sram_hs.sv
// tb/tb_tc_sram_hs.sv - self-checking bench for tc_sram_hs with a behavioural queue model
module tb_tc_sram_hs;

    localparam int NP    = 2;
    localparam int NW    = 1000;
    localparam int AW    = 10;
    localparam int DW    = 64;
    localparam int BW    = 8;
    localparam int LAT   = 3;
    localparam int DEPTH = 4;

    typedef struct {
        logic [63:0] data;
        logic        err;
        longint      due;
    } ent_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    bit   chk_en = 1'b0;
    int   n_checks = 0;
    int   n_fails = 0;

    ent_t        mq [NP][$];
    logic [63:0] mem_m [NW];
    longint      cyc = 0;

    always #5 clk = ~clk;

    tc_sram_hs_if #(.NumPorts(NP), .AddrWidth(AW), .DataWidth(DW), .BeWidth(BW)) bus ();

    tc_sram_hs #(
        .NumWords  (NW),
        .DataWidth (DW),
        .ByteWidth (8),
        .NumPorts  (NP),
        .Latency   (LAT),
        .RspDepth  (DEPTH),
        .SimInit   ("zeros")
    ) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus)
    );

    task automatic check_eq(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Reference model: each port keeps a queue of outstanding reads with the cycle their data is due.
    always @(posedge clk or negedge rst_n) begin : model
        bit   rd[NP];
        bit   wr[NP];
        int   a;
        ent_t e;
        if (!rst_n) begin
            for (int p = 0; p < NP; p++) mq[p].delete();
            for (int w = 0; w < NW; w++) mem_m[w] = '0;
            cyc = 0;
        end else begin
            for (int p = 0; p < NP; p++) begin
                bit rdy;
                bit vld;
                rdy = (mq[p].size() < DEPTH);
                vld = (mq[p].size() > 0) && (mq[p][0].due <= cyc);
                rd[p] = bus.req_valid_i[p] && rdy && !bus.req_we_i[p];
                wr[p] = bus.req_valid_i[p] && rdy && bus.req_we_i[p];
                if (vld && bus.rsp_ready_i[p]) void'(mq[p].pop_front());
            end
            for (int p = 0; p < NP; p++) begin
                if (rd[p]) begin
                    a = int'(bus.req_addr_i[p*AW +: AW]);
                    e.err  = (a >= NW);
                    e.data = e.err ? 64'd0 : mem_m[a];
                    e.due  = cyc + LAT;
                    mq[p].push_back(e);
                end
            end
            for (int p = 0; p < NP; p++) begin
                a = int'(bus.req_addr_i[p*AW +: AW]);
                if (wr[p] && a < NW) begin
                    for (int b = 0; b < BW; b++) begin
                        if (bus.req_be_i[p*BW + b]) mem_m[a][b*8 +: 8] = bus.req_wdata_i[p*DW + b*8 +: 8];
                    end
                end
            end
            cyc++;
        end
    end

    // Compare every port's outputs against the model once per cycle, away from the clock edge.
    always @(negedge clk) begin
        if (chk_en && rst_n) begin
            for (int p = 0; p < NP; p++) begin
                bit ev;
                ev = (mq[p].size() > 0) && (mq[p][0].due <= cyc);
                check_eq($sformatf("req_ready[%0d]", p), 64'(bus.req_ready_o[p]), 64'(mq[p].size() < DEPTH));
                check_eq($sformatf("rsp_valid[%0d]", p), 64'(bus.rsp_valid_o[p]), 64'(ev));
                if (ev && bus.rsp_valid_o[p]) begin
                    check_eq($sformatf("rsp_rdata[%0d]", p), bus.rsp_rdata_o[p*DW +: DW], mq[p][0].data);
                    check_eq($sformatf("rsp_err[%0d]", p), 64'(bus.rsp_err_o[p]), 64'(mq[p][0].err));
                end
            end
        end
    end

    task automatic issue(input int p, input bit we, input int a, input logic [63:0] d, input logic [7:0] be);
        bus.req_valid_i[p]         = 1'b1;
        bus.req_we_i[p]            = we;
        bus.req_addr_i[p*AW +: AW] = AW'(a);
        bus.req_wdata_i[p*DW +: DW] = d;
        bus.req_be_i[p*BW +: BW]   = be;
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
        bus.req_valid_i = '0;
    endtask

    // Called just after the accept edge; checks arrival latency and the literal payload.
    task automatic wait_rsp(input int p, input logic [63:0] ed, input logic ee, input string nm);
        int n;
        bit got;
        n = 1;
        got = 1'b0;
        while (n <= 20 && !got) begin
            if (bus.rsp_valid_o[p]) got = 1'b1;
            else begin
                tick();
                n++;
            end
        end
        check_eq({nm, "_arrived"}, 64'(got), 64'd1);
        check_eq({nm, "_latency"}, 64'(n), 64'(LAT));
        check_eq({nm, "_rdata"}, bus.rsp_rdata_o[p*DW +: DW], ed);
        check_eq({nm, "_err"}, 64'(bus.rsp_err_o[p]), 64'(ee));
        tick();
    endtask

    initial begin
        int acc;
        int got;
        int first;
        int last;
        int cnt;
        int a;

        bus.req_valid_i = '0;
        bus.req_we_i    = '0;
        bus.req_addr_i  = '0;
        bus.req_wdata_i = '0;
        bus.req_be_i    = '0;
        bus.rsp_ready_i = 2'b11;
        repeat (3) @(posedge clk);
        #2;
        check_eq("reset_req_ready", 64'(bus.req_ready_o), 64'h3);
        check_eq("reset_rsp_valid", 64'(bus.rsp_valid_o), 64'h0);
        check_eq("reset_rsp_rdata", 64'(bus.rsp_rdata_o[63:0]), 64'h0);
        check_eq("reset_rsp_err", 64'(bus.rsp_err_o), 64'h0);
        rst_n = 1'b1;
        chk_en = 1'b1;
        tick();

        // Zero-initialised read.
        issue(0, 1'b0, 5, 64'd0, 8'h00);
        tick();
        wait_rsp(0, 64'd0, 1'b0, "zero_rd");

        // Same-cycle, same-address writes: port 1 owns the low four bytes.
        issue(0, 1'b1, 3, 64'hAAAA_BBBB_CCCC_DDDD, 8'hFF);
        issue(1, 1'b1, 3, 64'h1111_1111_1111_1111, 8'h0F);
        tick();
        check_eq("model_mem3", mem_m[3], 64'hAAAA_BBBB_1111_1111);
        issue(0, 1'b0, 3, 64'd0, 8'h00);
        tick();
        wait_rsp(0, 64'hAAAA_BBBB_1111_1111, 1'b0, "wr_prio");

        // Read-before-write across ports.
        issue(1, 1'b1, 7, 64'h9, 8'hFF);
        tick();
        issue(0, 1'b0, 7, 64'd0, 8'h00);
        issue(1, 1'b1, 7, 64'h5, 8'hFF);
        tick();
        wait_rsp(0, 64'h9, 1'b0, "rbw_old");
        issue(0, 1'b0, 7, 64'd0, 8'h00);
        tick();
        wait_rsp(0, 64'h5, 1'b0, "rbw_new");

        // Backpressure: credits run out after DEPTH reads, then drain in order.
        for (int i = 0; i < DEPTH; i++) begin
            issue(0, 1'b1, 10 + i, 64'h100 + 64'(i), 8'hFF);
            tick();
        end
        bus.rsp_ready_i[0] = 1'b0;
        acc = 0;
        for (int c = 0; c < 8; c++) begin
            issue(0, 1'b0, 10 + acc, 64'd0, 8'h00);
            if (bus.req_ready_o[0]) acc++;
            tick();
        end
        check_eq("bp_accepts", 64'(acc), 64'(DEPTH));
        check_eq("bp_ready_low", 64'(bus.req_ready_o[0]), 64'd0);
        bus.rsp_ready_i[0] = 1'b1;
        got = 0;
        for (int c = 0; c < 20; c++) begin
            if (bus.rsp_valid_o[0]) begin
                check_eq($sformatf("bp_order%0d", got), bus.rsp_rdata_o[63:0], 64'h100 + 64'(got));
                got++;
            end
            tick();
        end
        check_eq("bp_count", 64'(got), 64'(DEPTH));
        check_eq("bp_ready_back", 64'(bus.req_ready_o[0]), 64'd1);

        // Full throughput on port 1.
        first = -1;
        last = -1;
        cnt = 0;
        for (int t = 0; t < 16 + 10; t++) begin
            if (t < 16) begin
                issue(1, 1'b0, t, 64'd0, 8'h00);
                check_eq($sformatf("tput_ready%0d", t), 64'(bus.req_ready_o[1]), 64'd1);
            end
            tick();
            if (bus.rsp_valid_o[1]) begin
                if (first < 0) first = t + 1;
                last = t + 1;
                cnt++;
            end
        end
        check_eq("tput_first", 64'(first), 64'(LAT));
        check_eq("tput_count", 64'(cnt), 64'd16);
        check_eq("tput_span", 64'(last - first), 64'd15);

        // Out-of-range accesses and the last in-range word.
        issue(0, 1'b0, 1010, 64'd0, 8'h00);
        tick();
        wait_rsp(0, 64'd0, 1'b1, "oor_rd");
        issue(0, 1'b1, 1010, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF);
        issue(1, 1'b1, 999, 64'hDEAD_BEEF_0000_0999, 8'hFF);
        tick();
        issue(1, 1'b0, 999, 64'd0, 8'h00);
        tick();
        wait_rsp(1, 64'hDEAD_BEEF_0000_0999, 1'b0, "last_word");
        issue(0, 1'b0, 1010, 64'd0, 8'h00);
        tick();
        wait_rsp(0, 64'd0, 1'b1, "oor_rd_again");
        issue(1, 1'b0, 1023, 64'd0, 8'h00);
        tick();
        wait_rsp(1, 64'd0, 1'b1, "oor_top");

        // Randomised traffic with one reset in the middle.
        for (int c = 0; c < 3000; c++) begin
            for (int p = 0; p < NP; p++) begin
                a = ($urandom_range(0, 9) == 0) ? int'($urandom_range(990, 1023)) : int'($urandom_range(0, 15));
                bus.req_valid_i[p]          = ($urandom_range(0, 99) < 60);
                bus.req_we_i[p]             = ($urandom_range(0, 2) == 0);
                bus.req_addr_i[p*AW +: AW]  = AW'(a);
                bus.req_wdata_i[p*DW +: DW] = {$urandom, $urandom};
                bus.req_be_i[p*BW +: BW]    = 8'($urandom_range(0, 255));
                bus.rsp_ready_i[p]          = ($urandom_range(0, 99) < 70);
            end
            if (c == 1500) rst_n = 1'b0;
            if (c == 1503) rst_n = 1'b1;
            @(posedge clk);
            #2;
        end

        bus.req_valid_i = '0;
        bus.rsp_ready_i = 2'b11;
        repeat (20) tick();
        check_eq("drain_ready", 64'(bus.req_ready_o), 64'h3);
        check_eq("drain_valid", 64'(bus.rsp_valid_o), 64'h0);

        chk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
